// File: rtl/bus_dma.sv
// bus_dma: word-granular block-copy engine, initiator side of the pCPU memory bus.
// Copies len 32-bit words from src to dst as read / gap / write / gap per word,
// honouring ready wait-states and aborting on the mapper's irq.
// Optional build macro: BUS_DMA_TIMEOUT_EN adds a per-transaction wait-state limit.
module bus_dma #(
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] remaining,
    output logic [31:0]      a,
    output logic [31:0]      d,
    output logic             we,
    output logic             rd,
    input  logic [31:0]      spo,
    input  logic             ready,
    input  logic             irq
);

    typedef enum logic [2:0] {IDLE, READ, RGAP, WRITE, WGAP, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] src_ptr, dst_ptr;
    logic        in_xfer;
    logic        tmo;
    logic        abort;

    assign in_xfer = (state == READ) || (state == WRITE);

`ifdef BUS_DMA_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
    logic [WC_W-1:0] wait_cnt;

    // Count stalled cycles of the current transaction; cleared outside READ/WRITE
    always_ff @(posedge clk) begin
        if (rst || !in_xfer)
            wait_cnt <= '0;
        else if (!ready)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Abort on the edge that closes the TIMEOUT_CYC-th stalled cycle
    assign tmo = in_xfer && !ready && (wait_cnt == WC_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    assign abort = in_xfer && (irq || tmo);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; an abort wins over a simultaneous ready
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = (len == '0) ? DONE : READ;
            READ:  if (abort) next_state = DONE;
                   else if (ready) next_state = RGAP;
            RGAP:  next_state = WRITE;
            WRITE: if (abort) next_state = DONE;
                   else if (ready) next_state = (remaining == LEN_W'(1)) ? DONE : WGAP;
            WGAP:  next_state = READ;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state == READ) || (state == RGAP) || (state == WRITE) || (state == WGAP);
        done = (state == DONE);
    end

    // Pointers, word count, error flag and read buffer (d doubles as the buffer)
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            err       <= 1'b0;
            d         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_ptr   <= {src[31:2], 2'b00};
                    dst_ptr   <= {dst[31:2], 2'b00};
                    remaining <= len;
                    err       <= 1'b0;
                end
                READ: begin
                    if (abort)      err <= 1'b1;
                    else if (ready) d   <= spo;
                end
                WRITE: begin
                    if (abort) err <= 1'b1;
                    else if (ready) begin
                        src_ptr   <= src_ptr + 32'd4;
                        dst_ptr   <= dst_ptr + 32'd4;
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus request registers, loaded from the next state so they settle at the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            a  <= '0;
            rd <= 1'b0;
            we <= 1'b0;
        end else begin
            rd <= (next_state == READ);
            we <= (next_state == WRITE);
            case (next_state)
                READ:    a <= (state == IDLE) ? {src[31:2], 2'b00} : src_ptr;
                WRITE:   a <= dst_ptr;
                default: a <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: randomized bench for bus_dma. A bus responder applies per-transaction
// stall counts and irq injection; expected transactions, done cycle, err and
// remaining come from a transaction-level model of the copy.
module tb_bus_dma;
    localparam int LW = 16;
    localparam int TO = 64;
`ifdef BUS_DMA_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, busy, done, err, we, rd, ready, irq;
    logic [31:0]   src, dst, a, d, spo;
    logic [LW-1:0] len, remaining;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_dma #(.LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err), .remaining(remaining),
        .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents seen by the engine: a fixed function of the word address
    function automatic logic [31:0] mem(input logic [31:0] addr);
        return (addr * 32'h9e37_79b1) ^ 32'h5a5a_1234;
    endfunction

    // One complete copy: model, stimulus, and per-cycle bus monitoring
    task automatic run_copy(input logic [31:0] s, input logic [31:0] dd, input int n,
                            input int abort_t, input int maxstall,
                            input int fix_j, input int fix_v, input bit poke);
        int          stall[$];
        logic [31:0] exp_a[$], exp_d[$];
        logic        exp_w[$];
        logic [31:0] ra, last_a;
        int          t_end, s_sum, exp_done, exp_rem, exp_cnt;
        bit          exp_err, seen_done, gap;
        int          txn, waited, cyc;

        for (int j = 0; j < 2 * n; j++)
            stall.push_back((maxstall > 0) ? $urandom_range(0, maxstall) : 0);
        if (fix_j >= 0 && fix_j < 2 * n) stall[fix_j] = fix_v;

        for (int k = 0; k < n; k++) begin
            ra = (s & ~32'h3) + 32'(4 * k);
            exp_a.push_back(ra);                         exp_d.push_back(mem(ra)); exp_w.push_back(1'b0);
            exp_a.push_back((dd & ~32'h3) + 32'(4 * k)); exp_d.push_back(mem(ra)); exp_w.push_back(1'b1);
        end

        // First aborting transaction (irq or wait-state limit), if any
        t_end = -1;
        s_sum = 0;
        for (int j = 0; j < 2 * n && t_end < 0; j++) begin
            if (j == abort_t) begin
                s_sum += stall[j];
                t_end = j;
            end else if (TMO_EN && stall[j] >= TO) begin
                s_sum += TO - 1;
                t_end = j;
            end else begin
                s_sum += stall[j];
            end
        end
        if (n == 0) begin
            exp_done = 1; exp_rem = 0; exp_err = 1'b0; exp_cnt = 0;
        end else if (t_end >= 0) begin
            exp_done = 2 + 2 * t_end + s_sum; exp_rem = n - t_end / 2;
            exp_err = 1'b1; exp_cnt = t_end;
        end else begin
            exp_done = 4 * n + s_sum; exp_rem = 0; exp_err = 1'b0; exp_cnt = 2 * n;
        end

        @(negedge clk);
        src = s; dst = dd; len = LW'(n); start = 1'b1; ready = 1'b0; irq = 1'b0;
        @(negedge clk);
        cyc = 1; txn = 0; waited = 0; seen_done = 1'b0; gap = 1'b0; last_a = '0;
        while (!seen_done && cyc < 2000) begin
            start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1; src = $urandom; dst = $urandom; len = LW'($urandom_range(1, 9));
            end
            if (cyc == 1) check("err_clear", 32'(err), 32'(exp_err && n == 0 ? 1'b0 : 1'b0));
            check("rd_we_excl", 32'(rd & we), 0);
            if (gap) begin
                check("gap_idle", 32'(rd | we), 0);
                gap = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_cyc", 32'(cyc), 32'(exp_done));
                check("done_busy", 32'(busy), 0);
                check("done_err", 32'(err), 32'(exp_err));
                check("done_rem", 32'(remaining), 32'(exp_rem));
                check("txn_count", 32'(txn), 32'(exp_cnt));
                start = 1'b1; src = $urandom; len = LW'($urandom_range(1, 9));
            end else begin
                check("busy", 32'(busy), 1);
            end
            if (rd || we) begin
                if (waited > 0) check("a_stable", a, last_a);
                last_a = a;
                if (txn >= 2 * n) begin
                    check("extra_txn", 32'(txn), 32'(2 * n));
                    ready = 1'b1; irq = 1'b0;
                end else if (txn == abort_t && waited >= stall[txn]) begin
                    irq = 1'b1; ready = 1'($urandom);
                    gap = 1'b1;
                end else if (waited >= stall[txn]) begin
                    ready = 1'b1; irq = 1'b0;
                    if (txn < exp_a.size()) begin
                        check("txn_addr", a, exp_a[txn]);
                        check("txn_dir", 32'(we), 32'(exp_w[txn]));
                        if (we) check("txn_data", d, exp_d[txn]);
                    end
                    txn++; waited = 0; gap = 1'b1;
                end else begin
                    ready = 1'b0; irq = 1'b0; waited++;
                end
                spo = rd ? mem(a) : $urandom;
            end else begin
                ready = 1'($urandom); irq = 1'($urandom); spo = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen_done) check("done_timeout", 0, 1);
        // start was held high across the DONE edge; it must not have been taken
        check("done_start_ignored", 32'(busy | done | rd), 0);
        start = 1'b0; ready = 1'b0; irq = 1'b0;
    endtask

    // Reset asserted while a write is outstanding
    task automatic reset_mid_write();
        @(negedge clk);
        src = 32'h3000_0000; dst = 32'h4000_0000; len = LW'(4); start = 1'b1; ready = 1'b0; irq = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !we; i++) begin
            ready = 1'b1; spo = $urandom;
            @(negedge clk);
        end
        check("rst_we_seen", 32'(we), 1);
        ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_a", a, 0);
        check("rst_d", d, 0);
        check("rst_wr", 32'({we, rd}), 0);
        check("rst_status", 32'({busy, done, err}), 0);
        check("rst_rem", 32'(remaining), 0);
        @(negedge clk);
        check("rst_idle", 32'({busy, done, rd, we}), 0);
    endtask

    initial begin
        int ab, n;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        spo = '0; ready = 1'b0; irq = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", a, 0);
        check("reset_d", d, 0);
        check("reset_we", 32'(we), 0);
        check("reset_rd", 32'(rd), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_rem", 32'(remaining), 0);
        rst = 1'b0;

        run_copy(32'h1000_0000, 32'h2000_0000, 3, -1, 0, -1, 0, 1'b0);
        run_copy(32'h1000_0000, 32'h2000_0000, 0, -1, 0, -1, 0, 1'b0);
        run_copy(32'h1000_0000, 32'h2000_0000, 3, -1, 0, 2, 5, 1'b1);
        run_copy(32'h1000_0000, 32'h2000_0000, 4, 3, 0, -1, 0, 1'b0);
        run_copy(32'hffff_fffc, 32'h5000_0000, 2, -1, 0, -1, 0, 1'b0);
        run_copy(32'h1000_0003, 32'h2000_0002, 2, -1, 1, -1, 0, 1'b1);
        reset_mid_write();

        for (int i = 0; i < 40; i++) begin
            n  = $urandom_range(0, 6);
            ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
            run_copy($urandom, $urandom, n, ab, 3, -1, 0, 1'($urandom));
        end

`ifdef BUS_DMA_TIMEOUT_EN
        run_copy(32'h6000_0000, 32'h7000_0000, 2, -1, 0, 0, TO + 10, 1'b0);
        run_copy(32'h6000_0000, 32'h7000_0000, 2, -1, 0, 3, TO + 10, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Word-granular block-copy engine; the initiator side of the pCPU memory bus (a/d/we/rd out, spo/ready/irq in).
- Sits as a second bus master in front of the address mapper, arbitrated with the CPU outside this block.
- Copies len 32-bit words from src to dst, one read then one write per word, honouring ready wait-states and the mapper's unmapped-address irq.

Parameters:
LEN_W, 16, width of the word-count input and remaining counter
TIMEOUT_CYC, 1024, wait-state limit per transaction (used only with BUS_DMA_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  command strobe; sampled only in IDLE
src  in  32  source byte address; bits [1:0] ignored
dst  in  32  destination byte address; bits [1:0] ignored
len  in  LEN_W  number of words to copy
busy  out  1  high while a copy is in progress
done  out  1  one-cycle pulse when a copy finishes or aborts
err  out  1  sticky abort flag, cleared by the next accepted start
remaining  out  LEN_W  words not yet written
a  out  32  bus address, bits [1:0] always 0
d  out  32  bus write data
we  out  1  bus write request
rd  out  1  bus read request
spo  in  32  bus read data, valid when ready=1
ready  in  1  bus completion, sampled at posedge while rd or we is high
irq  in  1  bus error from the mapper (unmapped address)

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE.
  - Outputs: a=0, d=0, we=0, rd=0, busy=0, done=0, err=0, remaining=0.
  - An in-flight rd/we drops at that edge.
- States: IDLE, READ, RGAP, WRITE, WGAP, DONE.
- IDLE:
  - start=1 latches src/dst (bits [1:0] cleared) and len, and clears err.
  - len=0 -> DONE; no bus cycle is issued.
  - Otherwise -> READ, busy=1.
- READ: rd=1, we=0, a=src pointer. Held stable until ready=1 at a posedge; then buf<=spo -> RGAP.
- RGAP: rd=we=0 for exactly one cycle -> WRITE. The gap guarantees a request edge for rd-edge-sensitive devices.
- WRITE: we=1, rd=0, a=dst pointer, d=buf. Held until ready=1. On completion:
  - src+=4 and dst+=4 (modulo 2^32, wrap 0xfffffffc->0x00000000 is legal).
  - remaining-=1.
  - remaining now 0 -> DONE, else -> WGAP.
- WGAP: one idle cycle -> READ.
- DONE: done=1 and busy=0 for one cycle -> IDLE.
- Bus error: irq=1 sampled in READ or WRITE aborts immediately.
  - rd/we drop at that edge; no pointer or count update; err=1 -> DONE.
  - remaining keeps the words not yet written.
- start is ignored whenever state!=IDLE, including in DONE.
- Latency with ready tied 1:
  - start sampled at edge 0; READ in cycle 1.
  - Each word takes 4 cycles; done is high in cycle 4*len.
  - busy is high in cycles 1..4*len-1.
- a, d, rd and we are registered outputs with no combinational path from ready/irq.
- The block only asserts one of rd or we at a time, never both.

Optional Feature:
- Macro: BUS_DMA_TIMEOUT_EN.
- Defined:
  - A wait counter resets on entry to READ/WRITE and increments each cycle ready=0.
  - At TIMEOUT_CYC stalled cycles the transaction aborts exactly as for irq: err=1 -> DONE.
- Undefined: no counter is built, and the engine waits on ready indefinitely.

Test Plan:
- ready=1, src=0x10000000, dst=0x20000000, len=3 -> three reads of 0x10000000/04/08 and writes to 0x20000000/04/08 with matching data; done in cycle 12; busy cycles 1..11; err=0.
- len=0 -> done in cycle 1; rd/we never asserted; busy stays 0.
- ready held 0 for 5 cycles in the 2nd READ -> a/rd stable for all 6 cycles; copy completes correctly; done in cycle 4*len+5.
- irq=1 during 2nd WRITE of len=4 -> we drops; done pulse next cycle with err=1 and remaining=3; next start clears err.
- src=0xfffffffc, len=2 -> second read address 0x00000000; src=0x10000003 -> bus address 0x10000000.
- rst mid-WRITE -> next cycle all outputs 0, state IDLE; start pulsed while busy is ignored. With BUS_DMA_TIMEOUT_EN and ready=0 forever: err=1 after TIMEOUT_CYC cycles.
